// File: rtl/ysyx_040066_div_pkg.sv
// ============================================================================
// Module  : ysyx_040066_div_pkg
// Brief   : Shared op encodings, FSM states and iteration counts for the
//           iterative divider.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package ysyx_040066_div_pkg;

   localparam logic [1:0] OP_DIV  = 2'b00;
   localparam logic [1:0] OP_DIVU = 2'b01;
   localparam logic [1:0] OP_REM  = 2'b10;
   localparam logic [1:0] OP_REMU = 2'b11;

   localparam int unsigned CNT_W = 7;
   localparam logic [CNT_W-1:0] N_64 = 7'd64;
   localparam logic [CNT_W-1:0] N_32 = 7'd32;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_e;

   function automatic logic [63:0] sext32(input logic [31:0] v);
      return {{32{v[31]}}, v};
   endfunction

endpackage

`default_nettype wire

// File: rtl/ysyx_040066_div_fixup.sv
// ============================================================================
// Module  : ysyx_040066_div_fixup
// Brief   : Sign correction, divide-by-zero / overflow selection and 32-bit
//           result sign-extension applied to the raw magnitude quotient.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_040066_div_fixup
   import ysyx_040066_div_pkg::*;
(
   input  logic [63:0] quo_i,
   input  logic [63:0] rem_i,
   input  logic [63:0] dividend_i,
   input  logic        neg_q_i,
   input  logic        neg_r_i,
   input  logic        div_zero_i,
   input  logic        ovf_i,
   input  logic        is_rem_i,
   input  logic        is_w_i,
   output logic [63:0] result_o
);

   logic [63:0] quo_s;
   logic [63:0] rem_s;
   logic [63:0] sel;

   always_comb begin
      quo_s = neg_q_i ? (64'd0 - quo_i) : quo_i;
      rem_s = neg_r_i ? (64'd0 - rem_i) : rem_i;
      if (div_zero_i) begin
         quo_s = '1;
         rem_s = dividend_i;
      end else if (ovf_i) begin
         quo_s = dividend_i;
         rem_s = '0;
      end
      sel      = is_rem_i ? rem_s : quo_s;
      result_o = is_w_i ? sext32(sel[31:0]) : sel;
   end

endmodule

`default_nettype wire

// File: rtl/ysyx_040066_div_iter.sv
// ============================================================================
// Module  : ysyx_040066_div_iter
// Brief   : Radix-2 restoring divider (div/divu/rem/remu and *W forms), one
//           quotient bit per unblocked cycle. Optional macro
//           YSYX_040066_DIV_FAST_SPECIAL_EN short-cuts div-by-zero/overflow.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_040066_div_iter
   import ysyx_040066_div_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            block,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] src1_in,
   input  logic [XLEN-1:0] src2_in,
   input  logic [1:0]      ALUctr_in,
   input  logic            is_w,
   output logic            out_valid,
   output logic [XLEN-1:0] result
);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [63:0]      quo_q, quo_d;
   logic [63:0]      rem_q, rem_d;
   logic [63:0]      dvs_q, dvs_d;
   logic [63:0]      dvd_q, dvd_d;
   logic             negq_q, negq_d;
   logic             negr_q, negr_d;
   logic             dz_q, dz_d;
   logic             ovf_q, ovf_d;
   logic             remop_q, remop_d;
   logic             w_q, w_d;
   logic [63:0]      result_q, result_d;

   logic             accept;
   logic             sgn_op;
   logic [63:0]      ext_a, ext_b, mag_a, mag_b;
   logic             sa, sb;
   logic             dz_acc, ovf_acc;
   logic             fast;
   logic [CNT_W-1:0] n_last;

   logic [64:0]      r_sh, r_sub;
   logic             ge;

   logic [63:0]      fix_quo, fix_rem, fix_dvd, fix_res;
   logic             fix_negq, fix_negr, fix_dz, fix_ovf, fix_remop, fix_w;

   // Operand preparation at accept: extend, detect specials, take magnitudes
   assign accept  = in_valid & in_ready & ~block & ~flush;
   assign sgn_op  = ~ALUctr_in[0];
   assign ext_a   = is_w ? (sgn_op ? sext32(src1_in[31:0]) : {32'd0, src1_in[31:0]}) : src1_in;
   assign ext_b   = is_w ? (sgn_op ? sext32(src2_in[31:0]) : {32'd0, src2_in[31:0]}) : src2_in;
   assign sa      = sgn_op & ext_a[63];
   assign sb      = sgn_op & ext_b[63];
   assign mag_a   = sa ? (64'd0 - ext_a) : ext_a;
   assign mag_b   = sb ? (64'd0 - ext_b) : ext_b;
   assign dz_acc  = (ext_b == 64'd0);
   assign ovf_acc = sgn_op & (ext_b == '1) &
                    (ext_a == (is_w ? sext32(32'h8000_0000) : 64'h8000_0000_0000_0000));
   assign n_last  = w_q ? N_32 : N_64;

   // A negative trial difference shows up as bit 64 set
   assign r_sh  = {rem_q, quo_q[63]};
   assign r_sub = r_sh - {1'b0, dvs_q};
   assign ge    = ~r_sub[64];

`ifdef YSYX_040066_DIV_FAST_SPECIAL_EN
   logic fix_acc;
   assign fix_acc   = (state_q == S_IDLE);
   assign fast      = accept & (dz_acc | ovf_acc);
   assign fix_quo   = fix_acc ? 64'd0        : quo_q;
   assign fix_rem   = fix_acc ? 64'd0        : rem_q;
   assign fix_dvd   = fix_acc ? ext_a        : dvd_q;
   assign fix_negq  = fix_acc ? 1'b0         : negq_q;
   assign fix_negr  = fix_acc ? 1'b0         : negr_q;
   assign fix_dz    = fix_acc ? dz_acc       : dz_q;
   assign fix_ovf   = fix_acc ? ovf_acc      : ovf_q;
   assign fix_remop = fix_acc ? ALUctr_in[1] : remop_q;
   assign fix_w     = fix_acc ? is_w         : w_q;
`else
   assign fast      = 1'b0;
   assign fix_quo   = quo_q;
   assign fix_rem   = rem_q;
   assign fix_dvd   = dvd_q;
   assign fix_negq  = negq_q;
   assign fix_negr  = negr_q;
   assign fix_dz    = dz_q;
   assign fix_ovf   = ovf_q;
   assign fix_remop = remop_q;
   assign fix_w     = w_q;
`endif

   ysyx_040066_div_fixup u_fixup (
      .quo_i      (fix_quo),
      .rem_i      (fix_rem),
      .dividend_i (fix_dvd),
      .neg_q_i    (fix_negq),
      .neg_r_i    (fix_negr),
      .div_zero_i (fix_dz),
      .ovf_i      (fix_ovf),
      .is_rem_i   (fix_remop),
      .is_w_i     (fix_w),
      .result_o   (fix_res)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = S_IDLE;
      end else if (!block) begin
         case (state_q)
            S_IDLE:  if (accept) state_d = fast ? S_DONE : S_CALC;
            S_CALC:  if (cnt_q == n_last) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      in_ready  = (state_q == S_IDLE);
      out_valid = (state_q == S_DONE);
   end

   assign result = result_q;

   // Last CALC cycle (cnt == N) only registers the fixed-up result
   always_comb begin
      cnt_d    = cnt_q;
      quo_d    = quo_q;
      rem_d    = rem_q;
      dvs_d    = dvs_q;
      dvd_d    = dvd_q;
      negq_d   = negq_q;
      negr_d   = negr_q;
      dz_d     = dz_q;
      ovf_d    = ovf_q;
      remop_d  = remop_q;
      w_d      = w_q;
      result_d = result_q;
      if (!flush && !block) begin
         if (accept) begin
            cnt_d   = '0;
            quo_d   = is_w ? {mag_a[31:0], 32'd0} : mag_a;
            dvs_d   = is_w ? {32'd0, mag_b[31:0]} : mag_b;
            rem_d   = '0;
            dvd_d   = ext_a;
            negq_d  = sa ^ sb;
            negr_d  = sa;
            dz_d    = dz_acc;
            ovf_d   = ovf_acc;
            remop_d = ALUctr_in[1];
            w_d     = is_w;
            if (fast) result_d = fix_res;
         end else if (state_q == S_CALC) begin
            if (cnt_q == n_last) begin
               result_d = fix_res;
            end else begin
               rem_d = ge ? r_sub[63:0] : r_sh[63:0];
               quo_d = {quo_q[62:0], ge};
               cnt_d = cnt_q + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         quo_q    <= '0;
         rem_q    <= '0;
         dvs_q    <= '0;
         dvd_q    <= '0;
         negq_q   <= 1'b0;
         negr_q   <= 1'b0;
         dz_q     <= 1'b0;
         ovf_q    <= 1'b0;
         remop_q  <= 1'b0;
         w_q      <= 1'b0;
         result_q <= '0;
      end else begin
         cnt_q    <= cnt_d;
         quo_q    <= quo_d;
         rem_q    <= rem_d;
         dvs_q    <= dvs_d;
         dvd_q    <= dvd_d;
         negq_q   <= negq_d;
         negr_q   <= negr_d;
         dz_q     <= dz_d;
         ovf_q    <= ovf_d;
         remop_q  <= remop_d;
         w_q      <= w_d;
         result_q <= result_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_ysyx_040066_div_iter.sv
// ============================================================================
// Module  : tb_ysyx_040066_div_iter
// Brief   : Self-checking bench for the iterative divider against an
//           arithmetic reference model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ysyx_040066_div_iter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        block = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [63:0] src1_in = '0;
   logic [63:0] src2_in = '0;
   logic [1:0]  ALUctr_in = '0;
   logic        is_w = 1'b0;
   logic        out_valid;
   logic [63:0] result;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   ysyx_040066_div_iter #(.XLEN(64)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .block     (block),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .src1_in   (src1_in),
      .src2_in   (src2_in),
      .ALUctr_in (ALUctr_in),
      .is_w      (is_w),
      .out_valid (out_valid),
      .result    (result)
   );

   // Directed vectors: dividend, divisor, op, W, expected result
   logic [63:0] t_a   [8] = '{64'd100, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF9,
                              64'h0000_0000_8000_0000, 64'h0000_0000_8000_0000, 64'd5, 64'd5};
   logic [63:0] t_b   [8] = '{64'd7, 64'd7, 64'd2, 64'd2,
                              64'h0000_0000_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF, 64'd0, 64'd0};
   logic [1:0]  t_op  [8] = '{2'b01, 2'b11, 2'b00, 2'b10, 2'b00, 2'b10, 2'b01, 2'b10};
   logic        t_w   [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
   logic [63:0] t_exp [8] = '{64'd14, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF,
                              64'hFFFF_FFFF_8000_0000, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5};

   function automatic logic [63:0] model(input logic [63:0] a, input logic [63:0] b,
                                         input logic [1:0] op, input logic w);
      logic [31:0] a32, b32, r32;
      logic [63:0] r64;
      logic        sgn;
      a32 = a[31:0];
      b32 = b[31:0];
      sgn = ~op[0];
      if (w) begin
         if (b32 == 32'd0)
            r32 = op[1] ? a32 : 32'hFFFF_FFFF;
         else if (sgn && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF)
            r32 = op[1] ? 32'd0 : a32;
         else begin
            case (op)
               2'b00:   r32 = $signed(a32) / $signed(b32);
               2'b01:   r32 = a32 / b32;
               2'b10:   r32 = $signed(a32) % $signed(b32);
               default: r32 = a32 % b32;
            endcase
         end
         r64 = {{32{r32[31]}}, r32};
      end else begin
         if (b == 64'd0)
            r64 = op[1] ? a : '1;
         else if (sgn && a == 64'h8000_0000_0000_0000 && b == '1)
            r64 = op[1] ? 64'd0 : a;
         else begin
            case (op)
               2'b00:   r64 = $signed(a) / $signed(b);
               2'b01:   r64 = a / b;
               2'b10:   r64 = $signed(a) % $signed(b);
               default: r64 = a % b;
            endcase
         end
      end
      return r64;
   endfunction

   // Edges from the accept edge to the edge that raises out_valid
   function automatic int exp_lat(input logic [63:0] a, input logic [63:0] b,
                                  input logic [1:0] op, input logic w);
      logic special;
      special = w ? ((b[31:0] == 32'd0) ||
                     (!op[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF))
                  : ((b == 64'd0) ||
                     (!op[0] && a == 64'h8000_0000_0000_0000 && b == '1));
`ifdef YSYX_040066_DIV_FAST_SPECIAL_EN
      if (special) return 0;
`else
      if (special) return (w ? 32 : 64) + 1;
`endif
      return (w ? 32 : 64) + 1;
   endfunction

   task automatic drive(input logic [63:0] a, input logic [63:0] b,
                        input logic [1:0] op, input logic w);
      src1_in   = a;
      src2_in   = b;
      ALUctr_in = op;
      is_w      = w;
   endtask

   task automatic wait_done(inout int lat);
      while (!out_valid && lat < 300) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic do_op(input logic [63:0] a, input logic [63:0] b, input logic [1:0] op,
                        input logic w, output logic [63:0] res, output int lat);
      @(negedge clk);
      drive(a, b, op, w);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      wait_done(lat);
      res = result;
      @(posedge clk); #1;
   endtask

   task automatic rand_operands(output logic [63:0] a, output logic [63:0] b,
                                output logic [1:0] op, output logic w);
      a  = {$urandom, $urandom};
      b  = {$urandom, $urandom};
      op = 2'($urandom_range(0, 3));
      w  = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 6))
         0: b = 64'($urandom_range(1, 20));
         1: b = {$urandom, 32'd0};
         2: begin b = '1; a = w ? {$urandom, 32'h8000_0000} : 64'h8000_0000_0000_0000; end
         3: a = a >> $urandom_range(0, 63);
         4: b = b >> $urandom_range(1, 63);
         default: ;
      endcase
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", out_valid); end
      checks++;
      if (result !== 64'd0) begin failures++; $display("FAIL reset_result: got %h want 0", result); end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b want 1", in_ready); end
   endtask

   task automatic test_directed();
      logic [63:0] res;
      int lat;
      for (int i = 0; i < 8; i++) begin
         do_op(t_a[i], t_b[i], t_op[i], t_w[i], res, lat);
         checks++;
         if (res !== t_exp[i]) begin
            failures++; $display("FAIL directed_%0d_result: got %h want %h", i, res, t_exp[i]);
         end
         checks++;
         if (lat != exp_lat(t_a[i], t_b[i], t_op[i], t_w[i])) begin
            failures++;
            $display("FAIL directed_%0d_latency: got %0d want %0d", i, lat,
                     exp_lat(t_a[i], t_b[i], t_op[i], t_w[i]));
         end
      end
   endtask

   task automatic test_random();
      logic [63:0] a, b, res, exp;
      logic [1:0]  op;
      logic        w;
      int lat;
      for (int i = 0; i < 60; i++) begin
         rand_operands(a, b, op, w);
         do_op(a, b, op, w, res, lat);
         exp = model(a, b, op, w);
         checks++;
         if (res !== exp) begin
            failures++;
            $display("FAIL random_%0d_result: op=%0d w=%0b a=%h b=%h got %h want %h", i, op, w, a, b, res, exp);
         end
         checks++;
         if (lat != exp_lat(a, b, op, w)) begin
            failures++; $display("FAIL random_%0d_latency: got %0d want %0d", i, lat, exp_lat(a, b, op, w));
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [63:0] a1, b1, a2, b2;
      int lat;
      a1 = 64'd1000; b1 = 64'd3;
      a2 = 64'hFFFF_FFFF_FFFF_FF00; b2 = 64'd16;
      @(negedge clk);
      drive(a1, b1, 2'b01, 1'b0);
      in_valid = 1'b1;
      @(posedge clk); #1;
      drive(a2, b2, 2'b00, 1'b0);
      checks++;
      if (in_ready !== 1'b0) begin failures++; $display("FAIL busy_ready: got %b want 0", in_ready); end
      lat = 0;
      wait_done(lat);
      checks++;
      if (result !== model(a1, b1, 2'b01, 1'b0)) begin
         failures++; $display("FAIL busy_ignore_result: got %h want %h", result, model(a1, b1, 2'b01, 1'b0));
      end
      checks++;
      if (lat != 65) begin failures++; $display("FAIL busy_ignore_latency: got %0d want 65", lat); end
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         failures++; $display("FAIL b2b_idle: got ready=%b valid=%b want ready=1 valid=0", in_ready, out_valid);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++;
      if (in_ready !== 1'b0) begin failures++; $display("FAIL b2b_accept: got ready=%b want 0", in_ready); end
      lat = 0;
      wait_done(lat);
      checks++;
      if (result !== model(a2, b2, 2'b00, 1'b0) || lat != 65) begin
         failures++;
         $display("FAIL b2b_second: got %h lat %0d want %h lat 65", result, lat, model(a2, b2, 2'b00, 1'b0));
      end
      @(posedge clk); #1;
   endtask

   task automatic test_block();
      logic [63:0] a, b, held;
      int lat;
      logic ok;
      a = {$urandom, $urandom};
      b = {$urandom, $urandom} | 64'd1;
      @(negedge clk);
      drive(a, b, 2'b00, 1'b0);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      repeat (20) begin @(posedge clk); #1; lat++; end
      block = 1'b1;
      ok = 1'b1;
      repeat (10) begin @(posedge clk); #1; lat++; if (out_valid !== 1'b0) ok = 1'b0; end
      block = 1'b0;
      checks++;
      if (!ok) begin failures++; $display("FAIL block_calc_valid: got 1 want 0 while blocked"); end
      wait_done(lat);
      checks++;
      if (lat != 75) begin failures++; $display("FAIL block_latency: got %0d want 75", lat); end
      checks++;
      if (result !== model(a, b, 2'b00, 1'b0)) begin
         failures++; $display("FAIL block_result: got %h want %h", result, model(a, b, 2'b00, 1'b0));
      end
      held = result;
      block = 1'b1;
      ok = 1'b1;
      repeat (10) begin @(posedge clk); #1; if (out_valid !== 1'b1 || result !== held) ok = 1'b0; end
      block = 1'b0;
      checks++;
      if (!ok) begin failures++; $display("FAIL block_done_hold: got valid=%b result=%h want 1 %h", out_valid, result, held); end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL block_release: got %b want 0", out_valid); end
   endtask

   task automatic test_flush();
      logic [63:0] a, b, res;
      logic [1:0]  op;
      logic        w;
      int lat;
      logic seen;
      @(negedge clk);
      drive(64'd12345, 64'd67, 2'b01, 1'b0);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         failures++; $display("FAIL flush_idle: got ready=%b valid=%b want 1 0", in_ready, out_valid);
      end
      seen = 1'b0;
      repeat (80) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
      checks++;
      if (seen) begin failures++; $display("FAIL flush_no_output: got out_valid=1 want 0"); end
      rand_operands(a, b, op, w);
      do_op(a, b, op, w, res, lat);
      checks++;
      if (res !== model(a, b, op, w) || lat != exp_lat(a, b, op, w)) begin
         failures++;
         $display("FAIL flush_next_op: got %h lat %0d want %h lat %0d", res, lat, model(a, b, op, w), exp_lat(a, b, op, w));
      end
      // flush in DONE wins over block
      @(negedge clk);
      drive(64'd77, 64'd7, 2'b01, 1'b1);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      wait_done(lat);
      block = 1'b1;
      flush = 1'b1;
      @(posedge clk); #1;
      block = 1'b0;
      flush = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         failures++; $display("FAIL flush_done: got valid=%b ready=%b want 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_reset_mid();
      logic [63:0] res;
      int lat;
      logic seen;
      @(negedge clk);
      drive(64'hDEAD_BEEF_0000_1234, 64'd9, 2'b11, 1'b0);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || result !== 64'd0 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_mid: got valid=%b result=%h ready=%b want 0 0 1", out_valid, result, in_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (80) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
      checks++;
      if (seen) begin failures++; $display("FAIL reset_mid_no_output: got out_valid=1 want 0"); end
      do_op(64'hFFFF_FFFF_8765_4321, 64'hFFFF_FFFF_FFFF_F000, 2'b10, 1'b1, res, lat);
      checks++;
      if (res !== model(64'hFFFF_FFFF_8765_4321, 64'hFFFF_FFFF_FFFF_F000, 2'b10, 1'b1) || lat != 33) begin
         failures++;
         $display("FAIL reset_mid_next_op: got %h lat %0d want %h lat 33", res, lat,
                  model(64'hFFFF_FFFF_8765_4321, 64'hFFFF_FFFF_FFFF_F000, 2'b10, 1'b1));
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_block();
      test_flush();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
